// File: rtl/cp0_int_unit.sv
// cp0_int_unit: CP0 interrupt unit.
//  - Synchronises three interrupt lines and latches their rising edges as pending.
//  - Holds the in-service mask (irs), the global enable (IE) and EPC.
//  - Stages one CP0 write and commits it on the following edge.
// Optional build macro: CP0_INT_DEBOUNCE_EN adds a per-line stability filter
// (DEBOUNCE_CYCLES) between the synchroniser and the edge detector.
module cp0_int_unit #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_int_lines,
    input  logic [31:0] i_pc_in,
    input  logic [3:0]  i_cp0_w_en,
    input  logic [3:0]  i_cp0_w_data,
    output logic        o_int,
    output logic [2:0]  o_ints,
    output logic [2:0]  o_irs,
    output logic        o_cp0_w_collision,
    output logic [31:0] o_epc
);

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_prev;
    logic [2:0]  r_pend;
    logic [2:0]  r_irs;
    logic        r_ie;
    logic [31:0] r_epc;
    logic        r_stg_valid;
    logic [3:0]  r_stg_en;
    logic [3:0]  r_stg_data;
    logic [31:0] r_stg_pc;

    logic [2:0]  w_clean;
    logic [2:0]  w_edge;
    logic [2:0]  w_irs_nx;
    logic [2:0]  w_pend_nx;
    logic [1:0]  w_hp;
    logic [1:0]  w_hs;

    // Level code of the highest set bit: bit k maps to level k+1, none maps to 0.
    function automatic logic [1:0] f_top_level(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Two-flop synchroniser for the raw interrupt lines.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= i_int_lines;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CP0_INT_DEBOUNCE_EN
    logic [15:0] r_db_cnt [3];
    logic [2:0]  r_filt;

    // Stability filter: a line's filtered value follows the synced value only
    // after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filt <= 3'b000;
            for (int k = 0; k < 3; k++) r_db_cnt[k] <= 16'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_filt[k]) begin
                    if (r_db_cnt[k] == DEBOUNCE_CYCLES - 16'd1) begin
                        r_filt[k]   <= r_sync2[k];
                        r_db_cnt[k] <= 16'd0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + 16'd1;
                    end
                end else begin
                    r_db_cnt[k] <= 16'd0;
                end
            end
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = r_sync2;
`endif

    assign w_edge = w_clean & ~r_prev;

    // Commit view of irs/pending: overwrite (bit2) first, then OR (bit0) on top;
    // a new edge on a line being cleared keeps it pending.
    always_comb begin
        w_irs_nx  = r_irs;
        w_pend_nx = r_pend | w_edge;
        if (r_stg_valid) begin
            if (r_stg_en[2]) w_irs_nx = r_stg_data[3:1];
            if (r_stg_en[0]) begin
                w_irs_nx  = w_irs_nx | r_stg_data[3:1];
                w_pend_nx = (r_pend & ~r_stg_data[3:1]) | w_edge;
            end
        end
    end

    // Edge history, pending, in-service state, IE and EPC.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 3'b000;
            r_pend <= 3'b000;
            r_irs  <= 3'b000;
            r_ie   <= 1'b1;
            r_epc  <= 32'd0;
        end else begin
            r_prev <= w_clean;
            r_pend <= w_pend_nx;
            r_irs  <= w_irs_nx;
            if (r_stg_valid && r_stg_en[1]) r_ie  <= r_stg_data[0];
            if (r_stg_valid && r_stg_en[3]) r_epc <= r_stg_pc;
        end
    end

    // One-deep write stage; requests arriving while it is full are dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stg_valid <= 1'b0;
            r_stg_en    <= 4'd0;
            r_stg_data  <= 4'd0;
            r_stg_pc    <= 32'd0;
        end else if (r_stg_valid) begin
            r_stg_valid <= 1'b0;
        end else if (i_cp0_w_en != 4'd0) begin
            r_stg_valid <= 1'b1;
            r_stg_en    <= i_cp0_w_en;
            r_stg_data  <= i_cp0_w_data;
            r_stg_pc    <= i_pc_in;
        end
    end

    assign w_hp              = f_top_level(r_pend);
    assign w_hs              = f_top_level(r_irs);
    assign o_int             = r_ie && (w_hp > w_hs);
    assign o_ints            = {1'b0, w_hp};
    assign o_irs             = r_irs;
    assign o_cp0_w_collision = r_stg_valid;
    assign o_epc             = r_epc;

endmodule

// File: tb/tb_cp0_int_unit.sv
// Testbench for cp0_int_unit: per-cycle vector table with a scoreboard queue,
// plus hand-written reset sequences (and the filter sequence when built with
// CP0_INT_DEBOUNCE_EN).
module tb_cp0_int_unit;

    typedef struct {
        logic [2:0]  lines;
        logic [3:0]  en;
        logic [3:0]  data;
        logic [31:0] pc;
        logic        e_int;
        logic [2:0]  e_ints;
        logic [2:0]  e_irs;
        logic        e_col;
        logic [31:0] e_epc;
    } vec_t;

    typedef struct {
        logic        e_int;
        logic [2:0]  e_ints;
        logic [2:0]  e_irs;
        logic        e_col;
        logic [31:0] e_epc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  int_lines;
    logic [31:0] pc_in;
    logic [3:0]  w_en;
    logic [3:0]  w_data;
    logic        o_int;
    logic [2:0]  o_ints;
    logic [2:0]  o_irs;
    logic        o_col;
    logic [31:0] o_epc;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;
    vec_t tbl[$];
    exp_t sb[$];

`ifdef CP0_INT_DEBOUNCE_EN
    cp0_int_unit #(.DEBOUNCE_CYCLES(16'd4)) dut (
`else
    cp0_int_unit dut (
`endif
        .i_clk             (clk),
        .i_rst             (rst),
        .i_int_lines       (int_lines),
        .i_pc_in           (pc_in),
        .i_cp0_w_en        (w_en),
        .i_cp0_w_data      (w_data),
        .o_int             (o_int),
        .o_ints            (o_ints),
        .o_irs             (o_irs),
        .o_cp0_w_collision (o_col),
        .o_epc             (o_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_int"},  {31'd0, o_int}, 32'd0);
        check({tag, "_ints"}, {29'd0, o_ints}, 32'd0);
        check({tag, "_irs"},  {29'd0, o_irs}, 32'd0);
        check({tag, "_col"},  {31'd0, o_col}, 32'd0);
        check({tag, "_epc"},  o_epc, 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] l, input logic [3:0] e, input logic [3:0] d,
                                input logic [31:0] p, input logic ei, input logic [2:0] es,
                                input logic [2:0] er, input logic ec, input logic [31:0] ep);
        vec_t v;
        v.lines = l; v.en = e; v.data = d; v.pc = p;
        v.e_int = ei; v.e_ints = es; v.e_irs = er; v.e_col = ec; v.e_epc = ep;
        return v;
    endfunction

    // Drive one cycle of stimulus (called right after a falling edge), push the
    // expected post-edge outputs, then pop and compare just after the rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        int_lines = v.lines; w_en = v.en; w_data = v.data; pc_in = v.pc;
        e.e_int = v.e_int; e.e_ints = v.e_ints; e.e_irs = v.e_irs;
        e.e_col = v.e_col; e.e_epc = v.e_epc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("int",  {31'd0, o_int},  {31'd0, g.e_int});
        check("ints", {29'd0, o_ints}, {29'd0, g.e_ints});
        check("irs",  {29'd0, o_irs},  {29'd0, g.e_irs});
        check("col",  {31'd0, o_col},  {31'd0, g.e_col});
        check("epc",  o_epc, g.e_epc);
        step_no++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; int_lines = 3'b000; pc_in = 32'd0; w_en = 4'd0; w_data = 4'd0;
        #2;
        check_zero_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

`ifdef CP0_INT_DEBOUNCE_EN
        // 2-cycle glitch on line 0 is filtered out.
        for (int i = 0; i < 2; i++)  step(mk(3'b001, 4'h0, 4'h0, 32'h0, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        for (int i = 0; i < 10; i++) step(mk(3'b000, 4'h0, 4'h0, 32'h0, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        // 6-cycle pulse: pending appears on the 7th edge after the rise.
        for (int i = 0; i < 6; i++)  step(mk(3'b001, 4'h0, 4'h0, 32'h0, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++)  step(mk(3'b000, 4'h0, 4'h0, 32'h0, 1'b1, 3'd1, 3'b000, 1'b0, 32'h0));
`else
        //          lines   en    data  pc           int   ints  irs     col   epc
        tbl.push_back(mk(3'b000, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 32'h0,      1'b1, 3'd2, 3'b000, 1'b0, 32'h0));
        tbl.push_back(mk(3'b010, 4'hB, 4'h4, 32'h40,     1'b1, 3'd2, 3'b000, 1'b1, 32'h0));
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b010, 4'h6, 4'h3, 32'h0,      1'b0, 3'd0, 3'b010, 1'b1, 32'h40));
        tbl.push_back(mk(3'b010, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b001, 1'b0, 32'h40));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b001, 1'b0, 32'h40));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b001, 1'b0, 32'h40));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b001, 1'b0, 32'h40));
        tbl.push_back(mk(3'b110, 4'h5, 4'hC, 32'h0,      1'b1, 3'd3, 3'b001, 1'b1, 32'h40));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b110, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b110, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd0, 3'b110, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b110, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h6, 4'h5, 32'h0,      1'b0, 3'd1, 3'b110, 1'b1, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b011, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b011, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h2, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b1, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd3, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h2, 4'h1, 32'h0,      1'b0, 3'd3, 3'b010, 1'b1, 32'h40));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h40));
        tbl.push_back(mk(3'b111, 4'h8, 4'h0, 32'h1234,   1'b1, 3'd3, 3'b010, 1'b1, 32'h40));
        tbl.push_back(mk(3'b111, 4'h8, 4'h0, 32'h5678,   1'b1, 3'd3, 3'b010, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b110, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b010, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h1, 4'h2, 32'h0,      1'b1, 3'd3, 3'b010, 1'b1, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b1, 3'd3, 3'b011, 1'b0, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h1, 4'h8, 32'h0,      1'b1, 3'd3, 3'b011, 1'b1, 32'h1234));
        tbl.push_back(mk(3'b111, 4'h0, 4'h0, 32'h0,      1'b0, 3'd1, 3'b111, 1'b0, 32'h1234));
        foreach (tbl[i]) step(tbl[i]);

        // Asynchronous reset in the middle of a cycle clears everything at once.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        // Lines still high appear as fresh rises; IE=1 after reset lets int fire.
        step(mk(3'b111, 4'h0, 4'h0, 32'h0, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        step(mk(3'b111, 4'h0, 4'h0, 32'h0, 1'b0, 3'd0, 3'b000, 1'b0, 32'h0));
        step(mk(3'b111, 4'h0, 4'h0, 32'h0, 1'b1, 3'd3, 3'b000, 1'b0, 32'h0));
`endif

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
